// File: rtl/dma_irq_coalesce_if.sv
// Event, configuration and status bundle between the transfer engine / register
// file (master side) and the interrupt coalescing controller (slave side).
interface dma_irq_coalesce_if #(
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 ioc_evt_i;
    logic                 err_evt_i;
    logic [CNT_WIDTH-1:0] irq_threshold_i;
    logic [CNT_WIDTH-1:0] irq_delay_i;
    logic                 ioc_irqen_i;
    logic                 dly_irqen_i;
    logic                 err_irqen_i;
    logic                 ioc_clr_i;
    logic                 dly_clr_i;
    logic                 err_clr_i;
    logic                 ioc_irq_o;
    logic                 dly_irq_o;
    logic                 err_irq_o;
    logic                 irq_o;
    logic [CNT_WIDTH-1:0] pend_cnt_o;
    logic [CNT_WIDTH-1:0] dly_cnt_o;

    modport master (
        output ioc_evt_i, err_evt_i, irq_threshold_i, irq_delay_i,
        output ioc_irqen_i, dly_irqen_i, err_irqen_i,
        output ioc_clr_i, dly_clr_i, err_clr_i,
        input  ioc_irq_o, dly_irq_o, err_irq_o, irq_o, pend_cnt_o, dly_cnt_o
    );

    modport slave (
        input  ioc_evt_i, err_evt_i, irq_threshold_i, irq_delay_i,
        input  ioc_irqen_i, dly_irqen_i, err_irqen_i,
        input  ioc_clr_i, dly_clr_i, err_clr_i,
        output ioc_irq_o, dly_irq_o, err_irq_o, irq_o, pend_cnt_o, dly_cnt_o
    );
endinterface

// File: rtl/dma_irq_coalesce.sv
// CDMA interrupt coalescing: IOC threshold counting, prescaled delay timeout,
// sticky IOC/Dly/Err status bits and the combined registered interrupt line.
module dma_irq_coalesce #(
    parameter int unsigned PRESCALE  = 125,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               soft_rst_i,
    dma_irq_coalesce_if.slave  bus
);
    localparam int unsigned PW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned CW1 = CNT_WIDTH + 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PW-1:0]        r_presc;
    logic [PW-1:0]        w_presc_nxt;
    logic [CNT_WIDTH-1:0] r_dly_cnt;
    logic [CNT_WIDTH-1:0] w_dly_cnt_nxt;
    logic [CNT_WIDTH-1:0] r_pend_cnt;
    logic [CNT_WIDTH-1:0] w_pend_cnt_nxt;
    logic                 r_ioc;
    logic                 r_dly;
    logic                 r_err;
    logic                 r_irq;
    logic                 w_ioc_nxt;
    logic                 w_dly_nxt;
    logic                 w_err_nxt;
    logic                 w_irq_nxt;

    logic                 w_clr;
    logic [CNT_WIDTH-1:0] w_thr_eff;
    logic [CW1-1:0]       w_pend_inc;
    logic                 w_fire;
    logic                 w_arm;
    logic                 w_tick;
    logic                 w_expire;

    // Event decode; an IOC event always takes precedence over timer expiry.
    assign w_clr      = rst | soft_rst_i;
    assign w_thr_eff  = (bus.irq_threshold_i == '0) ? CNT_WIDTH'(1) : bus.irq_threshold_i;
    assign w_pend_inc = {1'b0, r_pend_cnt} + CW1'(1);
    assign w_fire     = bus.ioc_evt_i & (w_pend_inc >= {1'b0, w_thr_eff});
    assign w_arm      = bus.ioc_evt_i & ~w_fire & (bus.irq_delay_i != '0);
    assign w_tick     = (r_state == S_RUN) & (r_presc == PRE_MAX);
    assign w_expire   = w_tick & (r_dly_cnt == CNT_WIDTH'(1)) & ~bus.ioc_evt_i;

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_arm) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.ioc_evt_i && !w_arm) begin
                    w_state_nxt = S_IDLE;
                end else if (w_expire) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values for counters, prescaler, status bits and the interrupt line.
    always_comb begin
        w_presc_nxt    = '0;
        w_dly_cnt_nxt  = '0;
        w_pend_cnt_nxt = r_pend_cnt;

        if (bus.ioc_evt_i) begin
            w_pend_cnt_nxt = w_fire ? '0 : w_pend_inc[CNT_WIDTH-1:0];
        end else if (w_expire) begin
            w_pend_cnt_nxt = '0;
        end

        if (w_arm) begin
            w_presc_nxt   = '0;
            w_dly_cnt_nxt = bus.irq_delay_i;
        end else if ((r_state == S_RUN) && (w_state_nxt == S_RUN)) begin
            w_presc_nxt   = w_tick ? '0 : r_presc + PW'(1);
            w_dly_cnt_nxt = w_tick ? r_dly_cnt - CNT_WIDTH'(1) : r_dly_cnt;
        end

        w_ioc_nxt = w_fire          | (r_ioc & ~bus.ioc_clr_i);
        w_dly_nxt = w_expire        | (r_dly & ~bus.dly_clr_i);
        w_err_nxt = bus.err_evt_i   | (r_err & ~bus.err_clr_i);
        w_irq_nxt = (r_ioc & bus.ioc_irqen_i) |
                    (r_dly & bus.dly_irqen_i) |
                    (r_err & bus.err_irqen_i);
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_presc    <= '0;
            r_dly_cnt  <= '0;
            r_pend_cnt <= '0;
            r_ioc      <= 1'b0;
            r_dly      <= 1'b0;
            r_err      <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_presc    <= w_presc_nxt;
            r_dly_cnt  <= w_dly_cnt_nxt;
            r_pend_cnt <= w_pend_cnt_nxt;
            r_ioc      <= w_ioc_nxt;
            r_dly      <= w_dly_nxt;
            r_err      <= w_err_nxt;
            r_irq      <= w_irq_nxt;
        end
    end

    assign bus.ioc_irq_o  = r_ioc;
    assign bus.dly_irq_o  = r_dly;
    assign bus.err_irq_o  = r_err;
    assign bus.irq_o      = r_irq;
    assign bus.pend_cnt_o = r_pend_cnt;
    assign bus.dly_cnt_o  = r_dly_cnt;
endmodule

// File: tb/tb_dma_irq_coalesce.sv
// Self-checking bench for dma_irq_coalesce: directed scenarios plus random
// traffic, compared every cycle against a deadline-based behavioural model.
module tb_dma_irq_coalesce;
    localparam int unsigned P  = 4;
    localparam int unsigned CW = 8;

    logic clk;
    logic rst;
    logic soft_rst;

    dma_irq_coalesce_if #(.CNT_WIDTH(CW)) u_if ();

    dma_irq_coalesce #(
        .PRESCALE  (P),
        .CNT_WIDTH (CW)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .soft_rst_i (soft_rst),
        .bus        (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model state: timer described by arming cycle and programmed delay.
    int m_pend = 0;
    int m_ioc  = 0;
    int m_dly  = 0;
    int m_err  = 0;
    int m_irq  = 0;
    int m_run  = 0;
    int m_arm  = 0;
    int m_d    = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        int c;
        int ev;
        int thr;
        int fire;
        int expire;
        int new_irq;
        c = cyc;
        if (rst || soft_rst) begin
            m_pend = 0; m_ioc = 0; m_dly = 0; m_err = 0; m_irq = 0; m_run = 0;
        end else begin
            ev      = int'(u_if.ioc_evt_i);
            thr     = (u_if.irq_threshold_i == 0) ? 1 : int'(u_if.irq_threshold_i);
            expire  = (m_run != 0 && c == m_arm + m_d * int'(P) && ev == 0) ? 1 : 0;
            fire    = (ev != 0 && m_pend + 1 >= thr) ? 1 : 0;
            new_irq = ((m_ioc != 0 && u_if.ioc_irqen_i) ||
                       (m_dly != 0 && u_if.dly_irqen_i) ||
                       (m_err != 0 && u_if.err_irqen_i)) ? 1 : 0;
            if (ev != 0) begin
                if (fire != 0) begin
                    m_pend = 0;
                    m_run  = 0;
                end else begin
                    m_pend++;
                    if (u_if.irq_delay_i != 0) begin
                        m_run = 1;
                        m_arm = c;
                        m_d   = int'(u_if.irq_delay_i);
                    end else begin
                        m_run = 0;
                    end
                end
            end else if (expire != 0) begin
                m_pend = 0;
                m_run  = 0;
            end
            m_ioc = (fire != 0 || (m_ioc != 0 && !u_if.ioc_clr_i)) ? 1 : 0;
            m_dly = (expire != 0 || (m_dly != 0 && !u_if.dly_clr_i)) ? 1 : 0;
            m_err = (u_if.err_evt_i || (m_err != 0 && !u_if.err_clr_i)) ? 1 : 0;
            m_irq = new_irq;
        end
        cyc++;
    endtask

    // One clock: model advances on the edge, DUT checked 1 time unit later.
    task automatic tick();
        int exp_dly;
        @(posedge clk);
        model_step();
        #1;
        exp_dly = (m_run != 0) ? m_d - (cyc - m_arm - 1) / int'(P) : 0;
        chk("ioc_irq",  int'(u_if.ioc_irq_o),  m_ioc);
        chk("dly_irq",  int'(u_if.dly_irq_o),  m_dly);
        chk("err_irq",  int'(u_if.err_irq_o),  m_err);
        chk("irq",      int'(u_if.irq_o),      m_irq);
        chk("pend_cnt", int'(u_if.pend_cnt_o), m_pend);
        chk("dly_cnt",  int'(u_if.dly_cnt_o),  exp_dly);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_ioc();
        u_if.ioc_evt_i = 1'b1;
        tick();
        u_if.ioc_evt_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic cfg(input int thr, input int dly, input bit ioc_en,
                       input bit dly_en, input bit err_en);
        u_if.irq_threshold_i = CW'(thr);
        u_if.irq_delay_i     = CW'(dly);
        u_if.ioc_irqen_i     = ioc_en;
        u_if.dly_irqen_i     = dly_en;
        u_if.err_irqen_i     = err_en;
    endtask

    task automatic clear_inputs();
        u_if.ioc_evt_i = 1'b0;
        u_if.err_evt_i = 1'b0;
        u_if.ioc_clr_i = 1'b0;
        u_if.dly_clr_i = 1'b0;
        u_if.err_clr_i = 1'b0;
        soft_rst       = 1'b0;
        rst            = 1'b0;
    endtask

    initial begin
        int prob;
        rst = 1'b1;
        soft_rst = 1'b0;
        clear_inputs();
        rst = 1'b1;
        cfg(0, 0, 1'b0, 1'b0, 1'b0);
        idle(2);
        rst = 1'b0;
        chk("rst_pend", int'(u_if.pend_cnt_o), 0);
        chk("rst_irq",  int'(u_if.irq_o), 0);

        // Threshold count with IOC interrupt.
        cfg(3, 0, 1'b1, 1'b0, 1'b0);
        pulse_ioc();
        chk("s1_pend1", int'(u_if.pend_cnt_o), 1);
        idle(4);
        pulse_ioc();
        chk("s1_pend2", int'(u_if.pend_cnt_o), 2);
        idle(4);
        pulse_ioc();
        chk("s1_ioc", int'(u_if.ioc_irq_o), 1);
        chk("s1_pend0", int'(u_if.pend_cnt_o), 0);
        chk("s1_irq_lag", int'(u_if.irq_o), 0);
        tick();
        chk("s1_irq", int'(u_if.irq_o), 1);
        u_if.ioc_clr_i = 1'b1;
        tick();
        u_if.ioc_clr_i = 1'b0;
        chk("s1_ioc_clr", int'(u_if.ioc_irq_o), 0);
        tick();
        chk("s1_irq_clr", int'(u_if.irq_o), 0);

        // Single IOC then delay expiry.
        do_reset();
        cfg(4, 2, 1'b0, 1'b1, 1'b0);
        pulse_ioc();
        chk("s2_dly2", int'(u_if.dly_cnt_o), 2);
        idle(4);
        chk("s2_dly1", int'(u_if.dly_cnt_o), 1);
        idle(3);
        chk("s2_nodly", int'(u_if.dly_irq_o), 0);
        tick();
        chk("s2_dly_irq", int'(u_if.dly_irq_o), 1);
        chk("s2_pend0", int'(u_if.pend_cnt_o), 0);
        chk("s2_dly0", int'(u_if.dly_cnt_o), 0);
        tick();
        chk("s2_irq", int'(u_if.irq_o), 1);

        // Rearm by a second IOC.
        do_reset();
        cfg(4, 2, 1'b0, 1'b1, 1'b0);
        pulse_ioc();
        idle(5);
        pulse_ioc();
        chk("s3_dly2", int'(u_if.dly_cnt_o), 2);
        idle(7);
        chk("s3_nodly", int'(u_if.dly_irq_o), 0);
        chk("s3_pend2", int'(u_if.pend_cnt_o), 2);
        tick();
        chk("s3_dly_irq", int'(u_if.dly_irq_o), 1);
        chk("s3_pend0", int'(u_if.pend_cnt_o), 0);

        // IOC coincident with the expiry tick wins.
        do_reset();
        cfg(4, 2, 1'b0, 1'b1, 1'b0);
        pulse_ioc();
        idle(7);
        pulse_ioc();
        chk("s4_nodly", int'(u_if.dly_irq_o), 0);
        chk("s4_pend2", int'(u_if.pend_cnt_o), 2);
        chk("s4_rearm", int'(u_if.dly_cnt_o), 2);
        do_reset();
        cfg(0, 2, 1'b1, 1'b0, 1'b0);
        pulse_ioc();
        chk("s4_thr0", int'(u_if.ioc_irq_o), 1);
        chk("s4_thr0_pend", int'(u_if.pend_cnt_o), 0);

        // Error set beats clear; enable gating.
        do_reset();
        cfg(4, 0, 1'b0, 1'b0, 1'b0);
        u_if.err_evt_i = 1'b1;
        u_if.err_clr_i = 1'b1;
        tick();
        u_if.err_evt_i = 1'b0;
        u_if.err_clr_i = 1'b0;
        chk("s5_err", int'(u_if.err_irq_o), 1);
        idle(2);
        chk("s5_irq_off", int'(u_if.irq_o), 0);
        u_if.err_irqen_i = 1'b1;
        tick();
        chk("s5_irq_on", int'(u_if.irq_o), 1);

        // Soft reset and hard reset mid-run; coincident IOC ignored.
        for (int k = 0; k < 2; k++) begin
            do_reset();
            cfg(4, 2, 1'b1, 1'b1, 1'b1);
            pulse_ioc();
            pulse_ioc();
            chk("s6_pend2", int'(u_if.pend_cnt_o), 2);
            if (k == 0) soft_rst = 1'b1; else rst = 1'b1;
            u_if.ioc_evt_i = 1'b1;
            u_if.err_evt_i = 1'b1;
            tick();
            clear_inputs();
            chk("s6_pend0", int'(u_if.pend_cnt_o), 0);
            chk("s6_dly0", int'(u_if.dly_cnt_o), 0);
            chk("s6_err0", int'(u_if.err_irq_o), 0);
            idle(12);
            chk("s6_nodly", int'(u_if.dly_irq_o), 0);
        end

        // Randomised traffic.
        prob = 4;
        for (int i = 0; i < 3000; i++) begin
            if (i % 150 == 0) begin
                cfg(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                    1'($urandom), 1'($urandom), 1'($urandom));
                prob = (i % 450 == 0) ? 2 : ((i % 300 == 0) ? 8 : 30);
            end
            if (i % 37 == 0) u_if.irq_threshold_i = CW'($urandom_range(0, 5));
            if (i % 53 == 0) u_if.irq_delay_i = CW'($urandom_range(0, 3));
            u_if.ioc_evt_i = ($urandom_range(0, prob - 1) == 0);
            u_if.err_evt_i = ($urandom_range(0, 15) == 0);
            u_if.ioc_clr_i = ($urandom_range(0, 7) == 0);
            u_if.dly_clr_i = ($urandom_range(0, 7) == 0);
            u_if.err_clr_i = ($urandom_range(0, 7) == 0);
            soft_rst       = ($urandom_range(0, 299) == 0);
            rst            = ($urandom_range(0, 499) == 0);
            tick();
        end
        clear_inputs();
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
